// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
// Holds default widths, the output buffer depth and the occupancy type.
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned ASIZE_DEF = 4;
  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] level_t;

endpackage

// File: rtl/fifo_rd_stream_skid2.sv
// stream_skid2: two-entry in-order buffer with a registered head.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous clear of occupancy (data left as-is)
//   push, din   write strobe and data; caller keeps push low when full
//               unless pop is also high
//   pop         removes the head word
//   dout        head word (buf0), valid when level != 0
//   valid       registered level != 0
//   level       occupancy 0..2
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [DSIZE-1:0] din,
  input  logic             pop,
  output logic [DSIZE-1:0] dout,
  output logic             valid,
  output level_t           level
);

  logic [DSIZE-1:0] buf0, buf1;
  logic [DSIZE-1:0] buf0_nxt, buf1_nxt;
  level_t           level_nxt;

  // A push lands in the first slot left free after any same-cycle pop,
  // so with push+pop at level 1 the new word goes straight to the head.
  always_comb begin
    buf0_nxt  = buf0;
    buf1_nxt  = buf1;
    level_nxt = level;
    case ({push, pop})
      2'b10: begin
        level_nxt = level + 2'd1;
        if (level == '0) buf0_nxt = din;
        else             buf1_nxt = din;
      end
      2'b01: begin
        level_nxt = level - 2'd1;
        buf0_nxt  = buf1;
      end
      2'b11: begin
        if (level == 2'd1) begin
          buf0_nxt = din;
        end else begin
          buf0_nxt = buf1;
          buf1_nxt = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0  <= '0;
      buf1  <= '0;
      level <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      level <= '0;
      valid <= 1'b0;
    end else begin
      buf0  <= buf0_nxt;
      buf1  <= buf1_nxt;
      level <= level_nxt;
      valid <= (level_nxt != '0);
    end
  end

  assign dout = buf0;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer of the async FIFO. Pops the FIFO
// into a 2-entry buffer and presents a valid/ready stream framed into
// PKT_LEN-beat packets.
// Ports:
//   rclk, rrst_n        read clock, asynchronous active-low reset
//   rdata, rempty, rinc FIFO head word, empty flag, pop strobe
//   flush               synchronous clear of buffer and beat counter
//   out_data/valid/ready/last  output stream, out_last on final beat
//   level               buffer occupancy 0..2
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE   = DSIZE_DEF,
  parameter int unsigned PKT_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output level_t           level
);

  localparam int unsigned    CW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(PKT_LEN - 1);
  localparam level_t         FULL      = level_t'(BUF_DEPTH);

  logic          hs;
  logic [CW-1:0] beat;

  // Gated only by registered occupancy, so out_ready never reaches rinc.
  assign rinc = !rempty && (level != FULL) && !flush;
  assign hs   = out_valid && out_ready;

  stream_skid2 #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk   (rclk),
    .rst_n (rrst_n),
    .flush (flush),
    .push  (rinc),
    .din   (rdata),
    .pop   (hs),
    .dout  (out_data),
    .valid (out_valid),
    .level (level)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat <= '0;
    end else if (flush) begin
      beat <= '0;
    end else if (hs) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end
  end

  assign out_last = out_valid && (beat == LAST_BEAT);

endmodule
